square_3bits: RTL and testbench
===============================

SQUARE_3BITS -- requirements
Module: square_3bits

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter CNT_W SHALL default to 8; it is the width of the accepted-sample counter, legal range 2..16.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the rising-edge clock.
REQ-004 Port rst_n SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
REQ-005 Port in_valid SHALL be an input, 1 bit wide, and qualifies the operand on in.
REQ-006 Port in SHALL be an input, 3 bits wide, and is the unsigned operand (0..7).
REQ-007 Port y SHALL be an output, 6 bits wide, and is the registered unsigned square of in.
REQ-008 Port out_valid SHALL be an output, 1 bit wide, and marks the cycle in which y is a new result.
REQ-009 Port sample_cnt SHALL be an output, CNT_W bits wide, and holds the saturating count of accepted operands.

Function
REQ-010 On each rising clk edge with in_valid=1, y SHALL load in*in, with 6-bit exact results 0,1,4,9,16,25,36,49 for in=0..7.
REQ-011 Latency SHALL be exactly 1 cycle: out_valid is 1 in the cycle after an accepted operand, and 0 otherwise.
REQ-012 With in_valid=0, y SHALL hold its last value and out_valid SHALL be 0.
REQ-013 Back-to-back operands (in_valid high every cycle) SHALL produce one result per cycle with no bubbles.
REQ-014 The square SHALL be formed by combinational shift-and-add of partial products (in[i] ? in<<i : 0), with no overflow possible, because 7*7=49 is less than 64.
REQ-015 X/Z on in while in_valid=0 SHALL NOT affect y.
REQ-016 sample_cnt SHALL increment by 1 per accepted operand and saturate at 2^CNT_W-1, with no wrap-around.
REQ-017 There is no backpressure; every operand presented with in_valid=1 SHALL be accepted.

Reset
REQ-018 Asserting rst_n=0 SHALL immediately, without waiting for clk, force y=0, out_valid=0 and sample_cnt=0.
REQ-019 Reset asserted mid-stream SHALL discard any in-flight result; the first operand accepted after release produces out_valid one cycle later.
REQ-020 Reset release SHALL be treated as synchronous to clk, so that the first rising edge with rst_n=1 may accept an operand.

Configuration
REQ-021 Macro SQUARE_3BITS_PARITY_EN, when defined, SHALL add a 1-bit output y_par that is registered alongside y and equals the XOR of y[5:0] (even parity), reset to 0.
REQ-022 Without SQUARE_3BITS_PARITY_EN, port y_par SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-023 Exhaustive sweep: in=0..7, one per cycle with in_valid=1 -> y=0,1,4,9,16,25,36,49 on consecutive cycles, out_valid=1 each cycle, sample_cnt=8.
REQ-024 Hold: in=5 accepted, then in_valid=0 with in=3 for 4 cycles -> y stays 25 and out_valid=0 throughout.
REQ-025 Async reset: while streaming in=6, drop rst_n between edges -> y=0, out_valid=0 and sample_cnt=0 without a clock edge; after release, in=2 -> y=4 one cycle later.
REQ-026 Saturation: CNT_W=2, 5 accepted operands -> sample_cnt=3 and remains 3.
REQ-027 Parity (with SQUARE_3BITS_PARITY_EN): in=7 -> y=49 (110001b), y_par=1; in=3 -> y=9, y_par=0.

Source files
------------

// File: rtl/square_3bits.sv
// square_3bits: registered 3-bit unsigned squarer with valid strobe,
// saturating accepted-sample counter and optional even-parity output.
// Ports: clk, rst_n (async low), in_valid, in[2:0] -> y[5:0], out_valid,
//   sample_cnt[CNT_W-1:0]; y_par only when SQUARE_3BITS_PARITY_EN defined.
module square_3bits #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       in,
  output logic [5:0]       y,
  output logic             out_valid,
`ifdef SQUARE_3BITS_PARITY_EN
  output logic             y_par,
`endif
  output logic [CNT_W-1:0] sample_cnt
);

  logic [5:0] pp0;
  logic [5:0] pp1;
  logic [5:0] pp2;
  logic [5:0] sq;

  // partial products in<<i gated by in[i]; max sum 49 fits 6 bits
  always_comb begin
    pp0 = in[0] ? {3'b000, in}       : 6'd0;
    pp1 = in[1] ? {2'b00, in, 1'b0}  : 6'd0;
    pp2 = in[2] ? {1'b0, in, 2'b00}  : 6'd0;
    sq  = pp0 + pp1 + pp2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= 6'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y <= sq;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
    end else if (in_valid && (sample_cnt != {CNT_W{1'b1}})) begin
      sample_cnt <= sample_cnt + 1'b1;
    end
  end

`ifdef SQUARE_3BITS_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_par <= 1'b0;
    end else if (in_valid) begin
      y_par <= ^sq;
    end
  end
`endif

endmodule

// File: tb/tb_square_3bits.sv
// tb_square_3bits: vector table, hand sequences and random stream
// against an arithmetic reference model of square_3bits.
module tb_square_3bits;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in;
  logic [5:0] y;
  logic       out_valid;
  logic [7:0] sample_cnt;
  logic [5:0] y2;
  logic       out_valid2;
  logic [1:0] sample_cnt2;
`ifdef SQUARE_3BITS_PARITY_EN
  logic       y_par;
  logic       y_par2;
`endif

  int total = 0;
  int bad = 0;

  int exp_y;
  int exp_ov;
  int exp_cnt;
  int exp_cnt2;

  square_3bits #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
    .y(y), .out_valid(out_valid),
`ifdef SQUARE_3BITS_PARITY_EN
    .y_par(y_par),
`endif
    .sample_cnt(sample_cnt)
  );

  square_3bits #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
    .y(y2), .out_valid(out_valid2),
`ifdef SQUARE_3BITS_PARITY_EN
    .y_par(y_par2),
`endif
    .sample_cnt(sample_cnt2)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1);
  end

  typedef struct {
    logic       v;
    logic [2:0] d;
    int         ey;
    int         eov;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: act=%0d req=%0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    exp_y = 0;
    exp_ov = 0;
    exp_cnt = 0;
    exp_cnt2 = 0;
  endtask

  // advance one edge and update the model from the inputs just sampled
  task automatic tick();
    @(posedge clk);
    #1;
    if (in_valid) begin
      exp_y = int'(in) * int'(in);
      exp_ov = 1;
      if (exp_cnt < 255) exp_cnt++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end else begin
      exp_ov = 0;
    end
  endtask

  task automatic step(input logic v, input logic [2:0] d);
    @(negedge clk);
    in_valid = v;
    in = d;
    tick();
  endtask

  task automatic check_model(input string tag);
    check({tag, ".y"}, int'(y), exp_y);
    check({tag, ".ov"}, int'(out_valid), exp_ov);
    check({tag, ".cnt"}, int'(sample_cnt), exp_cnt);
    check({tag, ".cnt2"}, int'(sample_cnt2), exp_cnt2);
`ifdef SQUARE_3BITS_PARITY_EN
    check({tag, ".par"}, int'(y_par), int'(^(6'(exp_y))));
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in = 3'd0;
    model_reset();

    #12;
    check("rst.y", int'(y), 0);
    check("rst.ov", int'(out_valid), 0);
    check("rst.cnt", int'(sample_cnt), 0);

    @(negedge clk);
    rst_n = 1'b1;

    // sweep 0..7 back to back, then hold with in=3 and valid low
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b1, 3'(i), i * i, 1});
    vecs.push_back('{1'b1, 3'd5, 25, 1});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{1'b0, 3'd3, 25, 0});

    foreach (vecs[k]) begin
      step(vecs[k].v, vecs[k].d);
      check($sformatf("vec%0d.y", k), int'(y), vecs[k].ey);
      check($sformatf("vec%0d.ov", k), int'(out_valid), vecs[k].eov);
      if (k == 7) check("sweep.cnt", int'(sample_cnt), 8);
    end
    check("sat.cnt2", int'(sample_cnt2), 3);
    check_model("tbl");

    // async reset between edges while streaming 6
    step(1'b1, 3'd6);
    step(1'b1, 3'd6);
    check("stream6.y", int'(y), 36);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.y", int'(y), 0);
    check("arst.ov", int'(out_valid), 0);
    check("arst.cnt", int'(sample_cnt), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    in = 3'd2;
    tick();
    check("post_rst.y", int'(y), 4);
    check("post_rst.ov", int'(out_valid), 1);
    check_model("post_rst");

    // saturation of the 2-bit counter
    for (int i = 0; i < 4; i++) step(1'b1, 3'(i));
    check("sat5.cnt2", int'(sample_cnt2), 3);
    step(1'b1, 3'd1);
    check("sat6.cnt2", int'(sample_cnt2), 3);

`ifdef SQUARE_3BITS_PARITY_EN
    step(1'b1, 3'd7);
    check("par7.y", int'(y), 49);
    check("par7.p", int'(y_par), 1);
    step(1'b1, 3'd3);
    check("par3.y", int'(y), 9);
    check("par3.p", int'(y_par), 0);
`endif

    // random stream against the model
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
